alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 147 ++++++++++++++
 tb/tb_alu_seq.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Sequential ALU with a valid/ready handshake on both sides.
// All ops finish in one cycle except MUL, which is an N-cycle shift-add.
module alu_seq #(
  parameter int N  = 16,
  parameter int SW = $clog2(N) + 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic [3:0]   flags
);

  localparam logic [3:0] OP_LOAD_A = 4'h1;
  localparam logic [3:0] OP_LOAD_B = 4'h3;
  localparam logic [3:0] OP_SUB    = 4'h4;
  localparam logic [3:0] OP_MUL    = 4'h5;
  localparam logic [3:0] OP_SHIFT  = 4'h8;
  localparam logic [3:0] OP_ADD    = 4'h9;
  localparam logic [3:0] OP_CMP    = 4'ha;
  localparam logic [3:0] OP_NEG    = 4'hb;
  localparam logic [3:0] OP_AND    = 4'hc;
  localparam logic [3:0] OP_OR     = 4'hd;
  localparam logic [3:0] OP_XOR    = 4'he;

  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state;
  logic [N-1:0]    result_q;
  logic [3:0]      flags_q;
  logic [2*N-1:0]  acc;
  logic [2*N-1:0]  mcand;
  logic [N-1:0]    mplier;
  logic [CW-1:0]   step;

  logic            accept;
  logic [SW-1:0]   amt;
  logic [N:0]      sum;
  logic [N:0]      diff;
  logic [N:0]      shl;
  logic [N:0]      shr;
  logic [N-1:0]    alu_res;
  logic            alu_c;
  logic            alu_v;
  logic [2*N-1:0]  acc_next;

  assign in_ready  = (state == IDLE) || (state == DONE && out_ready);
  assign out_valid = (state == DONE);
  assign result    = result_q;
  assign flags     = flags_q;
  assign accept    = in_valid && in_ready;

  // The extra bit on each shifter catches the last bit pushed out, which is the shift carry.
  assign amt  = b[SW-1:0];
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};
  assign shl  = {1'b0, a} << amt;
  assign shr  = {a, 1'b0} >> amt;

  assign acc_next = mplier[0] ? acc + mcand : acc;

  function automatic logic [3:0] make_flags(input logic [N-1:0] r, input logic c, input logic v);
    return {r == '0, c, r[N-1], v};
  endfunction

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op)
      OP_LOAD_A: alu_res = a;
      OP_LOAD_B: alu_res = b;
      OP_SHIFT: begin
        if (b[N-1]) begin
          alu_res = shl[N-1:0];
          alu_c   = shl[N];
        end else begin
          alu_res = shr[N:1];
          alu_c   = shr[0];
        end
      end
      OP_ADD: begin
        alu_res = sum[N-1:0];
        alu_c   = sum[N];
        alu_v   = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
      end
      OP_SUB: begin
        alu_res = diff[N-1:0];
        alu_c   = diff[N];
        alu_v   = (a[N-1] != b[N-1]) && (diff[N-1] != a[N-1]);
      end
      OP_CMP:  alu_res = {a == b, a < b, {(N-2){1'b0}}};
      OP_NEG:  alu_res = ~a;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      default: alu_res = '0;
    endcase
  end

  // MUL consumes one multiplier bit per BUSY cycle; everything else lands straight in DONE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      result_q <= '0;
      flags_q  <= '0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      step     <= '0;
    end else if (state == BUSY) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      step   <= step + 1'b1;
      if (step == LAST_STEP) begin
        state    <= DONE;
        result_q <= acc_next[N-1:0];
        flags_q  <= make_flags(acc_next[N-1:0], |acc_next[2*N-1:N], 1'b0);
      end
    end else if (accept) begin
      if (op == OP_MUL) begin
        state  <= BUSY;
        acc    <= '0;
        mcand  <= {{N{1'b0}}, a};
        mplier <= b;
        step   <= '0;
      end else begin
        state    <= DONE;
        result_q <= alu_res;
        flags_q  <= make_flags(alu_res, alu_c, alu_v);
      end
    end else if (state == DONE && out_ready) begin
      state <= IDLE;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed and random checks of alu_seq against an arithmetic reference model.
module tb_alu_seq;
  localparam int N = 16;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic [3:0]   op = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [N-1:0] result;
  logic [3:0]   flags;

  int n_checks = 0;
  int n_fail = 0;
  logic [N-1:0] last_result;
  logic [3:0]   last_flags;

  alu_seq #(.N(N)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns {flags, result} from plain integer arithmetic.
  function automatic logic [19:0] ref_model(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y);
    int ux, uy, sx, sy, t, amt;
    longint p;
    logic [15:0] r;
    logic c, v;
    ux = int'(x); uy = int'(y);
    sx = int'($signed(x)); sy = int'($signed(y));
    r = 0; c = 0; v = 0;
    case (o)
      4'h1: r = x;
      4'h3: r = y;
      4'h9: begin
        t = ux + uy; r = t[15:0]; c = (t > 65535);
        t = sx + sy; v = (t > 32767) || (t < -32768);
      end
      4'h4: begin
        t = ux - uy; r = t[15:0]; c = (ux < uy);
        t = sx - sy; v = (t > 32767) || (t < -32768);
      end
      4'h5: begin
        p = longint'(ux) * longint'(uy); r = p[15:0]; c = (p > 65535);
      end
      4'h8: begin
        amt = uy % 32;
        if (amt == 0) r = x;
        else if (amt <= 16) begin
          if (y[15]) begin
            t = (ux * (1 << amt)) % 65536; r = t[15:0];
            t = (ux >> (16 - amt)) % 2; c = t[0];
          end else begin
            t = ux >> amt; r = t[15:0];
            t = (ux >> (amt - 1)) % 2; c = t[0];
          end
        end
      end
      4'ha: begin
        t = ((ux == uy) ? 32768 : 0) + ((ux < uy) ? 16384 : 0); r = t[15:0];
      end
      4'hb: r = ~x;
      4'hc: r = x & y;
      4'hd: r = x | y;
      4'he: r = x ^ y;
      default: r = 0;
    endcase
    return {r == 16'h0, c, r[15], v, r};
  endfunction

  // Called at a negedge; returns at the negedge where the result is first visible.
  task automatic apply_stimulus(input string tag, input logic [3:0] o, input logic [15:0] x, input logic [15:0] y);
    logic [19:0] e;
    int lat, low;
    e = ref_model(o, x, y);
    op = o; a = x; b = y; in_valid = 1'b1;
    check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = N'($urandom); b = N'($urandom); op = 4'($urandom);
    lat = 1; low = 0;
    while (!out_valid && lat < 60) begin
      if (!in_ready) low++;
      @(negedge clk);
      lat++;
    end
    check_output(tag, (o == 4'h5) ? 17 : 1, (o == 4'h5) ? 16 : 0, lat, low, e);
  endtask

  task automatic check_output(input string tag, input int exp_lat, input int exp_low, input int lat, input int low, input logic [19:0] e);
    check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
    check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    check({tag, ".busy_cycles"}, 32'(low), 32'(exp_low));
    check({tag, ".result"}, 32'(result), 32'(e[15:0]));
    check({tag, ".flags"}, 32'(flags), 32'(e[19:16]));
    last_result = result;
    last_flags = flags;
  endtask

  initial begin
    logic [19:0] e;
    #12;
    check("rst.result", 32'(result), 32'd0);
    check("rst.flags", 32'(flags), 32'd0);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    check("rel.in_ready", 32'(in_ready), 32'd1);
    check("rel.out_valid", 32'(out_valid), 32'd0);

    apply_stimulus("add_ovf", 4'h9, 16'h7FFF, 16'h0001);
    check("add_ovf.lit_result", 32'(last_result), 32'h8000);
    check("add_ovf.lit_flags", 32'(last_flags), 32'b0011);

    apply_stimulus("mul", 4'h5, 16'h0100, 16'h0101);
    check("mul.lit_result", 32'(last_result), 32'h0100);
    check("mul.lit_carry", 32'(last_flags[2]), 32'd1);

    apply_stimulus("shl1", 4'h8, 16'h8001, 16'h8001);
    check("shl1.lit_result", 32'(last_result), 32'h0002);
    check("shl1.lit_carry", 32'(last_flags[2]), 32'd1);
    apply_stimulus("shr16", 4'h8, 16'h8001, 16'h0010);
    check("shr16.lit_result", 32'(last_result), 32'h0000);
    check("shr16.lit_zero", 32'(last_flags[3]), 32'd1);
    apply_stimulus("shift0", 4'h8, 16'hABCD, 16'h8000);
    apply_stimulus("shl16", 4'h8, 16'h0001, 16'h8010);
    apply_stimulus("shr17", 4'h8, 16'hFFFF, 16'h0011);

    apply_stimulus("b2b_xor", 4'he, 16'h00F0, 16'h0FF0);
    apply_stimulus("b2b_and", 4'hc, 16'h00F0, 16'h0FF0);
    apply_stimulus("b2b_cmp", 4'ha, 16'h0003, 16'h0005);
    check("b2b_cmp.lit_result", 32'(last_result), 32'h4000);

    apply_stimulus("undef", 4'h0, 16'h1234, 16'h5678);
    check("undef.lit_flags", 32'(last_flags), 32'b1000);
    apply_stimulus("sub_ovf", 4'h4, 16'h8000, 16'h0001);

    for (int i = 0; i < 60; i++)
      apply_stimulus("rand", 4'($urandom_range(0, 15)), N'($urandom), N'($urandom));

    // Stall the consumer on a SUB result while a new request waits.
    @(negedge clk);
    out_ready = 1'b0;
    apply_stimulus("stall_sub", 4'h4, 16'h0002, 16'h0003);
    e = ref_model(4'h4, 16'h0002, 16'h0003);
    in_valid = 1'b1; op = 4'h9; a = 16'h0001; b = 16'h0001;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall.out_valid", 32'(out_valid), 32'd1);
      check("stall.result", 32'(result), 32'hFFFF);
      check("stall.flags", 32'(flags), 32'(e[19:16]));
      check("stall.in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("stall.release_valid", 32'(out_valid), 32'd0);
    check("stall.release_ready", 32'(in_ready), 32'd1);

    // Reset while a result is held stalled.
    out_ready = 1'b0;
    apply_stimulus("rst_done_and", 4'hc, 16'hFFFF, 16'hFFFF);
    #3 reset_n = 1'b0;
    #1;
    check("rst_done.result", 32'(result), 32'd0);
    check("rst_done.flags", 32'(flags), 32'd0);
    check("rst_done.out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    out_ready = 1'b1;

    // Reset in the eighth BUSY cycle of a MUL.
    op = 4'h5; a = 16'h0100; b = 16'h0101; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    check("mid_mul.busy", 32'(in_ready), 32'd0);
    #2 reset_n = 1'b0;
    #1;
    check("mid_mul.out_valid", 32'(out_valid), 32'd0);
    check("mid_mul.result", 32'(result), 32'd0);
    check("mid_mul.flags", 32'(flags), 32'd0);
    check("mid_mul.in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst.out_valid", 32'(out_valid), 32'd0);
    end
    apply_stimulus("post_rst_add", 4'h9, 16'h0001, 16'h0001);
    check("post_rst_add.lit_result", 32'(last_result), 32'h0002);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
